// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped sequencer in front of uart_top.
// TX side: a small byte FIFO feeds a frame sequencer that issues one transmit
// pulse per byte and holds uartTxData stable until the next pulse.
// RX side: a capture FSM latches each received byte on rxInterrupt,
// acknowledges it with a one-cycle clearInterrupt pulse, then waits for the
// interrupt level to drop so that one level is never captured twice.
module uart_ctrl #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_CLKS     = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busWe,
    input  logic        busRe,
    input  logic [1:0]  busAddr,
    input  logic [31:0] busWdata,
    output logic [31:0] busRdata,
    output logic        irq,
    output logic        uartTransmit,
    output logic [7:0]  uartTxData,
    input  logic [7:0]  uartRxData,
    input  logic        uartRxIrq,
    input  logic        uartParityErr,
    output logic        uartClrIrq
);

    localparam int PTR_W      = $clog2(TX_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    // One frame slot: start + 8 data + parity + stop, plus the idle gap.
    localparam int FRAME_CLKS = 11 * CLKS_PER_BIT + GAP_CLKS;
    localparam int TMR_W      = $clog2(FRAME_CLKS);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CLR,
        RX_WAITLOW
    } rx_state_t;

    // ------------------------------------------------------------------
    // Bus decode. A read that collides with a write has no side effect.
    // ------------------------------------------------------------------
    logic wr_tx;
    logic wr_ctrl;
    logic rd_rx;
    logic ctrl_clr;

    assign wr_tx    = busWe && (busAddr == 2'd0);
    assign wr_ctrl  = busWe && (busAddr == 2'd3);
    assign rd_rx    = busRe && !busWe && (busAddr == 2'd1);
    assign ctrl_clr = wr_ctrl && busWdata[1];

    // Only the low byte of the write data is meaningful.
    logic unused_wdata;
    assign unused_wdata = ^busWdata[31:8];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TX_DEPTH-1:0][7:0] fifo_entries;
    logic [7:0] fifo_head;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    tx_state_t tx_state_q, tx_state_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    // A write to a full FIFO is dropped even if a pop happens that cycle.
    assign push       = wr_tx && !fifo_full;
    assign pop        = (tx_state_q == TX_LOAD);
    assign fifo_head  = fifo_entries[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < TX_DEPTH; gi++) begin : gen_entry
            logic [7:0] entry_q, entry_d;

            // Entry gi takes the written byte when the write pointer selects it.
            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = busWdata[7:0];
                end
            end

            // Entry storage register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign fifo_entries[gi] = entry_q;
        end
    endgenerate

    // Pointer and occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointer/count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Control and TX sticky flags
    // ------------------------------------------------------------------
    logic tx_ie_q, tx_ie_d;
    logic tx_ovf_q, tx_ovf_d;

    // CTRL bit0 is the TX-idle interrupt enable; a dropped byte sets txOverflow.
    always_comb begin
        tx_ie_d  = tx_ie_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_ctrl) begin
            tx_ie_d = busWdata[0];
        end
        if (ctrl_clr) begin
            tx_ovf_d = 1'b0;
        end
        if (wr_tx && fifo_full) begin
            tx_ovf_d = 1'b1;
        end
    end

    // Control/flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ie_q  <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            tx_ie_q  <= tx_ie_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // TX frame sequencer
    // The timer spans the whole slot: it is loaded with FRAME_CLKS-1 as the
    // pulse goes out and reaches 0 in the TX_IDLE cycle that follows the
    // wait, so back-to-back pulses are exactly FRAME_CLKS clocks apart.
    // uartTxData is loaded on entry to TX_LOAD so it is already valid while
    // the pulse is high and stays put until the next load.
    // ------------------------------------------------------------------
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic tx_pulse;

    // TX next-state, timer and transmit pulse.
    always_comb begin
        tx_state_d = tx_state_q;
        tmr_d      = tmr_q;
        tx_data_d  = tx_data_q;
        tx_pulse   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_state_d = TX_LOAD;
                    tx_data_d  = fifo_head;
                    tmr_d      = TMR_LOAD;
                end
            end
            TX_LOAD: begin
                tx_pulse   = 1'b1;
                tmr_d      = tmr_q - TMR_W'(1);
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == TMR_W'(1)) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tmr_q      <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tmr_q      <= tmr_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // RX capture
    // ------------------------------------------------------------------
    rx_state_t rx_state_q, rx_state_d;
    logic [7:0] rx_hold_q, rx_hold_d;
    logic rx_valid_q, rx_valid_d;
    logic rx_ovr_q, rx_ovr_d;
    logic rx_perr_q, rx_perr_d;
    logic rx_pop;
    logic rx_clr_pulse;

    // Reading RXDATA consumes the held byte only when one is present.
    assign rx_pop = rd_rx && rx_valid_q;

    // RX next-state, capture and acknowledge pulse.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_hold_d    = rx_hold_q;
        rx_valid_d   = rx_valid_q && !rx_pop;
        rx_ovr_d     = rx_ovr_q;
        rx_perr_d    = rx_perr_q;
        rx_clr_pulse = 1'b0;
        if (ctrl_clr) begin
            rx_ovr_d  = 1'b0;
            rx_perr_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (uartRxIrq) begin
                    rx_state_d = RX_CLR;
                    rx_perr_d  = rx_perr_d | uartParityErr;
                    // An unread byte is kept; a byte read this same cycle
                    // frees the holding register for the new one.
                    if (rx_valid_q && !rx_pop) begin
                        rx_ovr_d = 1'b1;
                    end else begin
                        rx_hold_d  = uartRxData;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            RX_CLR: begin
                rx_clr_pulse = 1'b1;
                rx_state_d   = RX_WAITLOW;
            end
            RX_WAITLOW: begin
                if (!uartRxIrq) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    logic tx_idle;
    assign tx_idle = fifo_empty && (tx_state_q == TX_IDLE);

    // Combinational read data; write-only and unmapped words read as 0.
    always_comb begin
        busRdata = '0;
        case (busAddr)
            2'd1: begin
                if (rx_valid_q) begin
                    busRdata = {24'h0, rx_hold_q};
                end
            end
            2'd2: begin
                busRdata = {25'h0, tx_ovf_q, tx_idle, fifo_empty, fifo_full,
                            rx_ovr_q, rx_perr_q, rx_valid_q};
            end
            default: begin
                busRdata = '0;
            end
        endcase
    end

    assign irq          = rx_valid_q | (tx_idle & tx_ie_q);
    assign uartTransmit = tx_pulse;
    assign uartTxData   = tx_data_q;
    assign uartClrIrq   = rx_clr_pulse;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl with a short frame (16 clks/bit, 4 gap clocks).
// uart_top is stood in for by the bench: transmit pulses are recorded by a
// monitor, and received frames are presented on the rxInterrupt handshake.
module tb_uart_ctrl;

    localparam int CPB   = 16;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 11 * CPB + GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busWe, busRe;
    logic [1:0]  busAddr;
    logic [31:0] busWdata, busRdata;
    logic        irq, uartTransmit, uartClrIrq;
    logic [7:0]  uartTxData, uartRxData;
    logic        uartRxIrq, uartParityErr;

    uart_ctrl #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .busWe(busWe), .busRe(busRe), .busAddr(busAddr),
        .busWdata(busWdata), .busRdata(busRdata), .irq(irq),
        .uartTransmit(uartTransmit), .uartTxData(uartTxData),
        .uartRxData(uartRxData), .uartRxIrq(uartRxIrq),
        .uartParityErr(uartParityErr), .uartClrIrq(uartClrIrq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Transmit pulses as seen by uart_top, and acknowledge pulse count.
    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];
    int         clr_count = 0;
    always @(negedge clk) begin
        if (uartTransmit === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(uartTxData);
        end
        if (uartClrIrq === 1'b1) clr_count++;
    end

    // Write schedule handed to the TX reference model.
    int         wr_c[32];
    logic [7:0] wr_d[32];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        busWe = 1'b1; busAddr = a; busWdata = d;
        tick();
        busWe = 1'b0; busWdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        busRe = 1'b1; busAddr = a;
        #1;
        d = busRdata;
        tick();
        busRe = 1'b0;
    endtask

    // Present one received frame and complete the rxInterrupt handshake.
    task automatic rx_frame(input logic [7:0] b, input logic p);
        bit seen = 0;
        uartRxData = b; uartParityErr = p; uartRxIrq = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (uartClrIrq === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rx_handshake: clearInterrupt got none, required one pulse for byte %h", b);
        end
        tick();
        uartRxIrq = 1'b0; uartParityErr = 1'b0;
        tick();
        tick();
        $display("rx frame %h perr=%0d delivered", b, p);
    endtask

    task automatic expect_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus_read(a, rd);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, rd, exp);
        end else begin
            $display("read %s addr=%0d data=%h", name, a, rd);
        end
    endtask

    // Reference model of the TX path: a byte pushed at cycle w goes out at
    // max(w+2, previous pulse + FRAME); it is dropped if DEPTH accepted bytes
    // are still waiting (not yet popped) in cycle w.
    task automatic check_tx_schedule(input int n, input string tag);
        int         ep_c[$];
        logic [7:0] ep_d[$];
        bit         drop = 0;
        int         prev = -100000;
        int         occ, pt, m;
        for (int i = 0; i < n; i++) begin
            occ = 0;
            foreach (ep_c[j]) if (ep_c[j] >= wr_c[i]) occ++;
            if (occ >= DEPTH) begin
                drop = 1;
            end else begin
                pt = wr_c[i] + 2;
                if (prev + FRAME > pt) pt = prev + FRAME;
                ep_c.push_back(pt);
                ep_d.push_back(wr_d[i]);
                prev = pt;
            end
        end
        if (ep_c.size() > 0) begin
            while (cyc < ep_c[ep_c.size()-1] + FRAME + 4) tick();
        end
        checks++;
        if (pulse_cyc.size() != ep_c.size()) begin
            errors++;
            $display("FAIL %s_pulse_count: got %0d required %0d", tag, pulse_cyc.size(), ep_c.size());
        end
        m = (pulse_cyc.size() < ep_c.size()) ? pulse_cyc.size() : ep_c.size();
        for (int k = 0; k < m; k++) begin
            checks += 2;
            if (pulse_cyc[k] !== ep_c[k]) begin
                errors++;
                $display("FAIL %s_pulse_time[%0d]: got cycle %0d required %0d", tag, k, pulse_cyc[k], ep_c[k]);
            end
            if (pulse_data[k] !== ep_d[k]) begin
                errors++;
                $display("FAIL %s_pulse_data[%0d]: got %h required %h", tag, k, pulse_data[k], ep_d[k]);
            end
            $display("tx pulse %0d cycle=%0d data=%h", k, pulse_cyc[k], pulse_data[k]);
        end
        expect_rd({tag, "_status"}, 2'd2, drop ? 32'h70 : 32'h30);
    endtask

    task automatic test_reset();
        repeat (5) tick();
        checks++;
        if ({uartTransmit, uartTxData, uartClrIrq, irq} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: got tx=%b data=%h clr=%b irq=%b required all 0",
                     uartTransmit, uartTxData, uartClrIrq, irq);
        end
        expect_rd("reset_status_in_reset", 2'd2, 32'h30);
        rst = 1'b1;
        tick();
        expect_rd("reset_status", 2'd2, 32'h30);
        expect_rd("reset_rxdata", 2'd1, 32'h0);
        expect_rd("reset_txdata_wo", 2'd0, 32'h0);
    endtask

    task automatic test_single_loopback();
        int t;
        int c0;
        pulse_cyc.delete(); pulse_data.delete();
        c0 = clr_count;
        t = cyc;
        bus_write(2'd0, 32'h2E);
        for (int i = 0; i < 10 && pulse_cyc.size() == 0; i++) tick();
        checks++;
        if (pulse_cyc.size() == 0) begin
            errors++;
            $display("FAIL single_pulse: got no pulse required one at cycle %0d", t + 2);
        end else begin
            checks += 2;
            if (pulse_cyc[0] !== t + 2) begin
                errors++;
                $display("FAIL single_latency: got cycle %0d required %0d", pulse_cyc[0], t + 2);
            end
            if (pulse_data[0] !== 8'h2E) begin
                errors++;
                $display("FAIL single_data: got %h required 2e", pulse_data[0]);
            end
            repeat (FRAME) tick();
            rx_frame(pulse_data[0], 1'b0);
        end
        expect_rd("loop_status", 2'd2, 32'h31);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL loop_irq: got %b required 1", irq);
        end
        expect_rd("loop_rxdata", 2'd1, 32'h2E);
        expect_rd("loop_status_after", 2'd2, 32'h30);
        checks++;
        if (clr_count - c0 !== 1) begin
            errors++;
            $display("FAIL loop_clr_pulses: got %0d required 1", clr_count - c0);
        end
    endtask

    task automatic test_tx_burst();
        pulse_cyc.delete(); pulse_data.delete();
        for (int i = 0; i < 6; i++) begin
            wr_c[i] = cyc;
            wr_d[i] = 8'(i + 1);
            bus_write(2'd0, 32'(i + 1));
        end
        // 0x01 has already been popped; 0x02..0x05 fill the FIFO, 0x06 dropped.
        expect_rd("burst_full_status", 2'd2, 32'h48);
        check_tx_schedule(6, "burst");
        bus_write(2'd3, 32'h2);
        expect_rd("burst_cleared", 2'd2, 32'h30);
    endtask

    task automatic test_tx_random();
        int r, gapc;
        pulse_cyc.delete(); pulse_data.delete();
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      gapc = $urandom_range(100, 250);
            else if (r < 4)  gapc = 0;
            else             gapc = $urandom_range(1, 3);
            repeat (gapc) tick();
            wr_c[i] = cyc;
            wr_d[i] = 8'($urandom);
            bus_write(2'd0, {24'h0, wr_d[i]});
        end
        check_tx_schedule(10, "rand");
        bus_write(2'd3, 32'h2);
    endtask

    task automatic test_irq();
        bus_write(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_txie_idle: got %b required 1", irq); end
        bus_write(2'd0, 32'h5A);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b required 0", irq); end
        repeat (FRAME + 4) tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_again: got %b required 1", irq); end
        bus_write(2'd3, 32'h0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b required 0", irq); end
        $display("irq enable/disable sequence done");
    endtask

    task automatic test_rx_overrun();
        rx_frame(8'hFE, 1'b0);
        rx_frame(8'h03, 1'b0);
        expect_rd("ovr_status", 2'd2, 32'h35);
        expect_rd("ovr_rxdata", 2'd1, 32'hFE);
        bus_write(2'd3, 32'h2);
        expect_rd("ovr_cleared", 2'd2, 32'h30);
        expect_rd("ovr_empty_read", 2'd1, 32'h0);
    endtask

    task automatic test_rx_parity();
        rx_frame(8'hA5, 1'b1);
        expect_rd("perr_status", 2'd2, 32'h33);
        expect_rd("perr_rxdata", 2'd1, 32'hA5);
        bus_write(2'd3, 32'h2);
        expect_rd("perr_cleared", 2'd2, 32'h30);
    endtask

    task automatic test_read_capture();
        logic [31:0] rd;
        rx_frame(8'h11, 1'b0);
        busRe = 1'b1; busAddr = 2'd1;
        uartRxData = 8'h22; uartRxIrq = 1'b1;
        #1;
        rd = busRdata;
        tick();
        busRe = 1'b0;
        checks += 2;
        if (rd !== 32'h11) begin errors++; $display("FAIL rc_old_byte: got %h required 11", rd); end
        if (uartClrIrq !== 1'b1) begin errors++; $display("FAIL rc_clr: got %b required 1", uartClrIrq); end
        tick();
        uartRxIrq = 1'b0;
        tick(); tick();
        expect_rd("rc_status", 2'd2, 32'h31);
        expect_rd("rc_new_byte", 2'd1, 32'h22);
    endtask

    task automatic test_rx_random();
        bit          m_valid = 0, m_ovr = 0, m_perr = 0;
        logic [7:0]  m_hold = 0, b;
        logic        p;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    b = 8'($urandom);
                    p = m_valid ? 1'b0 : ($urandom_range(0, 3) == 0);
                    rx_frame(b, p);
                    if (m_valid) m_ovr = 1;
                    else begin m_hold = b; m_valid = 1; end
                    m_perr |= p;
                end
                1: begin
                    expect_rd("rrand_rxdata", 2'd1, m_valid ? {24'h0, m_hold} : 32'h0);
                    m_valid = 0;
                end
                2: expect_rd("rrand_status", 2'd2, 32'h30 | {29'h0, m_ovr, m_perr, m_valid});
                default: begin
                    bus_write(2'd3, 32'h2);
                    m_ovr = 0; m_perr = 0;
                end
            endcase
        end
        expect_rd("rrand_final_status", 2'd2, 32'h30 | {29'h0, m_ovr, m_perr, m_valid});
        bus_write(2'd3, 32'h2);
        expect_rd("rrand_drain", 2'd1, m_valid ? {24'h0, m_hold} : 32'h0);
    endtask

    task automatic test_reset_mid_frame();
        int t;
        t = cyc;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h40 + 32'(i));
        while (cyc < t + 60) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({uartTransmit, uartTxData, uartClrIrq, irq} !== 11'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got tx=%b data=%h clr=%b irq=%b required all 0",
                     uartTransmit, uartTxData, uartClrIrq, irq);
        end
        tick(); tick();
        pulse_cyc.delete(); pulse_data.delete();
        rst = 1'b1;
        tick();
        expect_rd("midrst_status", 2'd2, 32'h30);
        repeat (2 * FRAME + 40) tick();
        checks++;
        if (pulse_cyc.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_pulse: got %0d pulses required 0", pulse_cyc.size());
        end
        $display("reset mid-frame done");
    endtask

    initial begin
        busWe = 1'b0; busRe = 1'b0; busAddr = 2'd0; busWdata = '0;
        uartRxData = '0; uartRxIrq = 1'b0; uartParityErr = 1'b0;
        test_reset();
        test_single_loopback();
        test_tx_burst();
        test_tx_random();
        test_irq();
        test_rx_overrun();
        test_rx_parity();
        test_read_capture();
        test_rx_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
